// File: rtl/mem_write_buffer_pkg.sv
// Shared constants and the per-cycle buffer operation encoding for the
// memory write buffer.
package mem_write_buffer_pkg;

    localparam int DATA_W     = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 32;

    // Encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

    function automatic buf_op_e buf_op(input logic push, input logic pop);
        return buf_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/mem_write_buffer_fwd_match.sv
// Store-to-load forwarding match: compares the lookup word address against
// every live entry and returns the data of the youngest match.
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int WA_W   = 30,
    parameter int DATA_W = 32
) (
    input  logic [WA_W-1:0]          addr_i [DEPTH],
    input  logic [DATA_W-1:0]        data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [WA_W-1:0]          look_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_i) && (addr_i[idx] == look_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between the core data port and external memory:
// circular FIFO of word writes, drained in order, with read forwarding.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       mem_din,
    output logic              stall,
    output logic              empty,
    output logic [ADDR_W-1:0] ext_raddr,
    input  logic [31:0]       ext_rdata,
    output logic              ext_wreq,
    output logic [ADDR_W-1:0] ext_waddr,
    output logic [31:0]       ext_wdata,
    input  logic              ext_wack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WA_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              full;
    logic              push;
    logic              pop;
    buf_op_e           op;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              unused_ren;

    // Reads always return the forwarding rule, whether or not a read is live.
    assign unused_ren = mem_ren;

    assign full  = (count_q == FULL_CNT);
    assign push  = mem_wen && !full;
    assign pop   = (count_q != '0) && ext_wack;
    assign op    = buf_op(push, pop);

    assign stall     = mem_wen && full;
    assign empty     = (count_q == '0);
    assign ext_wreq  = (count_q != '0);
    assign ext_waddr = {addr_q[head_q], 2'b00};
    assign ext_wdata = data_q[head_q];
    assign ext_raddr = mem_addr;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (op)
            OP_PUSH: begin
                tail_d  = tail_q + 1'b1;
                count_d = count_q + 1'b1;
            end
            OP_POP: begin
                head_d  = head_q + 1'b1;
                count_d = count_q - 1'b1;
            end
            OP_BOTH: begin
                head_d = head_q + 1'b1;
                tail_d = tail_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset; count_q alone decides which are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[tail_q] <= mem_addr[ADDR_W-1:2];
            data_q[tail_q] <= mem_dout;
        end
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .WA_W   (WA_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .addr_i  (addr_q),
        .data_i  (data_q),
        .head_i  (head_q),
        .count_i (count_q),
        .look_i  (mem_addr[ADDR_W-1:2]),
        .hit_o   (fwd_hit),
        .data_o  (fwd_data)
    );

    assign mem_din = fwd_hit ? fwd_data : ext_rdata;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Randomized bench for mem_write_buffer: queue-based reference model for
// status and forwarding, plus a drain scoreboard checked by a monitor.
module tb_mem_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;
  logic [31:0]       mem_din;
  logic              stall;
  logic              empty;
  logic [ADDR_W-1:0] ext_raddr;
  logic [31:0]       ext_rdata;
  logic              ext_wreq;
  logic [ADDR_W-1:0] ext_waddr;
  logic [31:0]       ext_wdata;
  logic              ext_wack;

  ent_t        model_q[$];
  logic [63:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .stall     (stall),
    .empty     (empty),
    .ext_raddr (ext_raddr),
    .ext_rdata (ext_rdata),
    .ext_wreq  (ext_wreq),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .ext_wack  (ext_wack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drain monitor: every accepted external write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && ext_wreq === 1'b1 && ext_wack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_unexpected: got write %h<=%h expected none", ext_waddr, ext_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("drain_addr", ext_waddr, e[63:32]);
        check("drain_data", ext_wdata, e[31:0]);
      end
    end
  end

  // Expected combinational outputs derived from the model queue.
  task automatic check_outputs(input logic wen, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] din_exp;
    din_exp = rdata;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].wa == addr[31:2]) begin
        din_exp = model_q[i].d;
        break;
      end
    end
    check("stall", 32'(stall), 32'(wen && (model_q.size() == DEPTH)));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("ext_wreq", 32'(ext_wreq), 32'(model_q.size() != 0));
    check("ext_raddr", ext_raddr, addr);
    check("mem_din", mem_din, din_exp);
    if (model_q.size() != 0) begin
      check("head_addr", ext_waddr, {model_q[0].wa, 2'b00});
      check("head_data", ext_wdata, model_q[0].d);
    end
  endtask

  // Driver: apply one cycle of inputs, check before the edge, update model after it.
  task automatic step(input logic wen, input logic ren, input logic [31:0] addr,
                      input logic [31:0] wd, input logic wack, input logic r,
                      input logic [31:0] rdata);
    int sz;
    mem_wen   = wen;
    mem_ren   = ren;
    mem_addr  = addr;
    mem_dout  = wd;
    ext_wack  = wack;
    rst       = r;
    ext_rdata = rdata;
    @(negedge clk);
    check_outputs(wen, addr, rdata);
    @(posedge clk);
    sz = model_q.size();
    if (r) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (sz != 0 && wack) void'(model_q.pop_front());
      if (wen && sz < DEPTH) begin
        ent_t e;
        e.wa = addr[31:2];
        e.d  = wd;
        model_q.push_back(e);
        exp_q.push_back({addr[31:2], 2'b00, wd});
      end
    end
    #1;
  endtask

  task automatic idle(input logic wack);
    step(1'b0, 1'b0, 32'h0000_0040, 32'h0, wack, 1'b0, 32'h1234_5678);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic wack);
    step(1'b1, 1'b0, addr, d, wack, 1'b0, 32'h0BAD_0BAD);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 4 * DEPTH + 4 && model_q.size() != 0; i++) idle(1'b1);
    check("drain_done", 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    ext_rdata = '0;
    ext_wack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, including mem_din passthrough.
    step(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001);
    idle(1'b0);

    // First write appears on the external port one cycle later.
    wr(32'h100, 32'hAAAA_0001, 1'b0);
    idle(1'b0);
    drain_all();

    // Fill, stall on the fifth write, ack while stalled, then retry.
    wr(32'h0, 32'h1000_0000, 1'b0);
    wr(32'h4, 32'h1000_0004, 1'b0);
    wr(32'h8, 32'h1000_0008, 1'b0);
    wr(32'hC, 32'h1000_000C, 1'b0);
    wr(32'h10, 32'h1000_0010, 1'b0);
    wr(32'h10, 32'h1000_0010, 1'b1);
    wr(32'h10, 32'h1000_0010, 1'b0);
    drain_all();

    // Forwarding of the youngest duplicate; miss falls through to ext_rdata.
    wr(32'h20, 32'h1, 1'b0);
    wr(32'h20, 32'h2, 1'b0);
    step(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 32'hDEAD);
    step(1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 1'b0, 32'hDEAD);
    step(1'b0, 1'b1, 32'h23, 32'h0, 1'b1, 1'b0, 32'hDEAD);
    step(1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 32'hDEAD);
    idle(1'b0);

    // Simultaneous push/pop at count 2, then wrap over ten writes.
    wr(32'h30, 32'h3000_0000, 1'b0);
    wr(32'h34, 32'h3000_0004, 1'b0);
    wr(32'h38, 32'h3000_0008, 1'b1);
    for (int i = 0; i < 10; i++) wr(32'h200 + 32'(i * 4), 32'h5A00_0000 + 32'(i), 1'b1);
    drain_all();

    // Reset mid-drain with a simultaneous ack abandons everything.
    wr(32'h40, 32'h4000_0000, 1'b0);
    wr(32'h44, 32'h4000_0004, 1'b0);
    wr(32'h48, 32'h4000_0008, 1'b0);
    step(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);
    idle(1'b1);
    idle(1'b1);

    // Ack with an empty buffer has no effect.
    idle(1'b1);
    idle(1'b1);
    wr(32'h50, 32'h5000_0000, 1'b1);
    idle(1'b0);
    drain_all();

    // Random traffic over a small address window to exercise forwarding.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0), $urandom);
    end
    drain_all();
    idle(1'b0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered word writes; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  main clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 mem_ren  input  1  core data read enable.
REQ-006 mem_wen  input  1  core data write enable.
REQ-007 mem_addr  input  ADDR_W  core data byte address; bits [1:0] ignored (word access only).
REQ-008 mem_dout  input  32  core write data.
REQ-009 mem_din  output  32  read data returned to core, same cycle.
REQ-010 stall  output  1  write not accepted this cycle; controller holds the pipeline.
REQ-011 empty  output  1  buffer holds no entries.
REQ-012 ext_raddr  output  ADDR_W  external memory asynchronous read address.
REQ-013 ext_rdata  input  32  external memory read data, combinational from ext_raddr.
REQ-014 ext_wreq  output  1  external write request.
REQ-015 ext_waddr  output  ADDR_W  external write address, word-aligned.
REQ-016 ext_wdata  output  32  external write data.
REQ-017 ext_wack  input  1  external write accepted this cycle; meaningful only while ext_wreq=1.

Function
REQ-018 Buffer SHALL be a circular FIFO of DEPTH entries {word address ADDR_W-1:2, data 32}, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-019 Push: mem_wen=1 and count<DEPTH -> entry written at tail on the edge, tail+1, count+1; stall=0.
REQ-020 Full: mem_wen=1 and count==DEPTH -> no push, stall=1 combinationally; a pop in the same cycle does not clear stall (push retried next cycle).
REQ-021 stall SHALL be 0 whenever mem_wen=0.
REQ-022 Drain: ext_wreq=(count!=0); ext_waddr/ext_wdata = head entry (ext_waddr[1:0]=0); held stable until ext_wack.
REQ-023 Pop: ext_wreq=1 and ext_wack=1 -> head+1, count-1 on the edge.
REQ-024 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-025 ext_wack while count==0 SHALL be ignored.
REQ-026 Read: ext_raddr=mem_addr always; mem_din = data of the youngest entry whose word address equals mem_addr[ADDR_W-1:2], else ext_rdata.
REQ-027 Forwarding SHALL include the head entry even while it is being acked that cycle.
REQ-028 Multiple entries to the same address SHALL be kept (no coalescing); drained in program order.
REQ-029 When mem_ren=0, mem_din SHALL follow the same rule (value is don't-care to the core).
REQ-030 empty=(count==0); latency push-to-ext_wreq = 1 cycle when previously empty.

Reset
REQ-031 rst=1 on a rising edge -> head=0, tail=0, count=0; buffered data discarded.
REQ-032 Outputs during/after reset: ext_wreq=0, empty=1, stall=0 unless mem_wen=1 with count==DEPTH (impossible after reset), mem_din=ext_rdata.
REQ-033 Reset mid-drain: pending write abandoned; ext_wreq deasserts the cycle after the reset edge; a simultaneous ext_wack is ignored.
REQ-034 Reset SHALL take priority over push and pop in the same cycle.

Structure
REQ-035 DEPTH default and pointer width log2(DEPTH) SHALL be defined as constants in define.vh.
REQ-036 Single module; the forwarding match is a natural sub-module wb_fwd_match (DEPTH comparators + youngest-first priority select).
REQ-037 Entry storage SHALL be registers, not inferred RAM (parallel compare required).

Verification
REQ-038 Reset, then write 0x100<=0xAAAA0001 with ext_wack=0 -> next cycle ext_wreq=1, ext_waddr=0x100, ext_wdata=0xAAAA0001, empty=0.
REQ-039 Four writes 0x0,0x4,0x8,0xC with ext_wack=0, fifth write to 0x10 -> stall=1 on fifth; ack once -> fifth accepted following cycle, drain order 0x0,0x4,0x8,0xC,0x10.
REQ-040 Writes 0x20<=1 then 0x20<=2 buffered, read 0x20 with ext_rdata=0xDEAD -> mem_din=2; read 0x24 -> mem_din=0xDEAD.
REQ-041 Count=2, push and ack same cycle -> count stays 2, head and tail each advance by one; wrap past DEPTH-1 verified over 10 writes with data intact.
REQ-042 Count=3 with ext_wreq=1, assert rst and ext_wack together -> next cycle ext_wreq=0, empty=1, no further external writes.
REQ-043 ext_wack pulsed with buffer empty -> count stays 0, no underflow.
